// File: rtl/vgade0_i2c_master_pkg.sv
// Shared constants for the vgade0 I2C display master: command geometry and FSM encodings.
package vgade0_i2c_master_pkg;

    localparam int unsigned COMMAND_WIDTH = 48;
    localparam int unsigned COMMAND_BYTES = 6;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StStart   = 3'd1;
    localparam state_t StAddr    = 3'd2;
    localparam state_t StAddrAck = 3'd3;
    localparam state_t StData    = 3'd4;
    localparam state_t StDataAck = 3'd5;
    localparam state_t StStop    = 3'd6;

    // Shared SCL pattern of every 4-quarter bit slot: low in Q0 and Q3.
    function automatic logic bit_scl_low(input logic [1:0] qtr);
        return (qtr == 2'd0) || (qtr == 2'd3);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period strobe for the I2C master: one tick every CLK_DIV clk cycles while enabled.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 62
) (
    input  logic clk,
    input  logic reset_button,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick = enable && (cnt_q == CntW'(CLK_DIV - 1));

    // Held at zero while disabled so the first quarter after IDLE is a full one.
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/vgade0_i2c_master.sv
// Write-only I2C master sending a 48-bit display command to SLAVE_ADDR.
// Define I2C_RETRY_EN to retry an address NACK up to three times before reporting it.
module vgade0_i2c_master
    import vgade0_i2c_master_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned CLK_DIV    = 62
) (
    input  logic                     clk,
    input  logic                     reset_button,
    input  logic                     cmd_valid,
    input  logic [COMMAND_WIDTH-1:0] command,
    output logic                     cmd_ready,
    output logic                     done,
    output logic                     nack,
    output logic                     scl_drive_low,
    output logic                     sda_drive_low,
    input  logic                     sda_in
);

    state_t                   state_q, state_d;
    logic [1:0]               qtr_q, qtr_d;
    logic [2:0]               bit_q, bit_d;
    logic [2:0]               byte_q, byte_d;
    logic [COMMAND_WIDTH-1:0] shreg_q, shreg_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic                     nack_q, nack_d;
    logic                     live_q;
    logic                     tick;
    logic                     retry_now;
    logic [7:0]               addr_byte;
    logic [7:0]               cur_byte;

    assign addr_byte = {SLAVE_ADDR, 1'b0};
    assign cur_byte  = shreg_q[COMMAND_WIDTH-1 -: 8];

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_quarter_tick (
        .clk         (clk),
        .reset_button(reset_button),
        .enable      (state_q != StIdle),
        .tick        (tick)
    );

`ifdef I2C_RETRY_EN
    logic [1:0] retry_q;
    logic       addr_err_q;

    assign retry_now = err_q && addr_err_q && (retry_q != 2'd3);

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            retry_q    <= '0;
            addr_err_q <= 1'b0;
        end else if (state_q == StIdle) begin
            retry_q    <= '0;
            addr_err_q <= 1'b0;
        end else if (tick && (qtr_q == 2'd2)) begin
            if (state_q == StAddrAck) begin
                addr_err_q <= sda_in;
            end else if (state_q == StStop && retry_now) begin
                retry_q    <= retry_q + 2'd1;
                addr_err_q <= 1'b0;
            end
        end
    end
`else
    assign retry_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        err_d   = err_q;
        done_d  = 1'b0;
        nack_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = StStart;
                    qtr_d   = '0;
                    byte_d  = '0;
                    err_d   = 1'b0;
                    shreg_d = command;
                end
            end
            StStart: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd1) begin
                        state_d = StAddr;
                        qtr_d   = '0;
                        bit_d   = 3'd7;
                    end
                end
            end
            StAddr, StData: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = (state_q == StAddr) ? StAddrAck : StDataAck;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            StAddrAck, StDataAck: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // Sample on the last clk of Q2, just before SCL is pulled low again.
                    if (qtr_q == 2'd2) begin
                        err_d = sda_in;
                    end
                    if (qtr_q == 2'd3) begin
                        bit_d = 3'd7;
                        if (err_q) begin
                            state_d = StStop;
                        end else if (state_q == StAddrAck) begin
                            state_d = StData;
                        end else if (byte_q == 3'(COMMAND_BYTES - 1)) begin
                            state_d = StStop;
                        end else begin
                            state_d = StData;
                            byte_d  = byte_q + 3'd1;
                            shreg_d = shreg_q << 8;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        qtr_d = '0;
                        if (retry_now) begin
                            state_d = StStart;
                            err_d   = 1'b0;
                        end else begin
                            state_d = StIdle;
                            done_d  = !err_q;
                            nack_d  = err_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state_q <= StIdle;
            qtr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            err_q   <= err_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
            live_q  <= 1'b1;
        end
    end

    assign cmd_ready = live_q && (state_q == StIdle);
    assign done      = done_q;
    assign nack      = nack_q;

    // Line drive is decoded from state only, so reset releases both lines immediately.
    always_comb begin
        scl_drive_low = 1'b0;
        sda_drive_low = 1'b0;
        unique case (state_q)
            StStart: begin
                scl_drive_low = (qtr_q == 2'd1);
                sda_drive_low = 1'b1;
            end
            StAddr: begin
                scl_drive_low = bit_scl_low(qtr_q);
                sda_drive_low = !addr_byte[bit_q];
            end
            StData: begin
                scl_drive_low = bit_scl_low(qtr_q);
                sda_drive_low = !cur_byte[bit_q];
            end
            StAddrAck, StDataAck: begin
                scl_drive_low = bit_scl_low(qtr_q);
            end
            StStop: begin
                scl_drive_low = (qtr_q == 2'd0);
                sda_drive_low = (qtr_q != 2'd2);
            end
            default: ;
        endcase
    end

endmodule
